req_capture_pe: RTL and testbench
=================================

# req_capture_pe

Request capture and grant stage placed directly upstream of the 4-input priority encoder. It latches four request lines into a pending register and selects the highest-index pending request with the same encoding rule as the encoder. The selected index is presented on a registered valid/ready output, and the serviced pending bit is cleared when the consumer accepts the index.

## Interface
Parameters:
- EDGE, 1: 1 = capture rising edges of req_in; 0 = capture level (any high bit sets pending every cycle).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  4  request lines; bit 3 has highest priority.
- out_ready  in  1  consumer accepts out_idx when high with out_valid.
- clr_ovf  in  1  clears the sticky overflow flag.
- out_valid  out  1  out_idx holds a granted request.
- out_idx  out  2  encoded index of the granted request (3..0).
- pending  out  4  current pending register.
- overflow  out  1  sticky flag: a request arrived while its bit was already pending.

## Operation
- Capture, EDGE=1:
  - rise = req_in & ~req_q; req_q <= req_in every cycle.
- Capture, EDGE=0:
  - rise = req_in.
- Clear mask: one-hot of out_idx when (out_valid & out_ready), else 0.
- Pending update: pending <= (pending & ~clear) | rise.
  - Set wins over clear on the same bit in the same cycle.
- Encode rule, applied to pending:
  - bit3 -> 3, else bit2 -> 2, else bit1 -> 1, else bit0 -> 0.
  - pending == 0 never produces a grant.
- FSM, two states:
  - IDLE: out_valid=0. If pending != 0, then out_idx <= encode(pending), out_valid <= 1, go to HOLD.
  - HOLD: out_idx and out_valid are stable. On out_ready, clear the granted pending bit, out_valid <= 0, go to IDLE.
- The grant is frozen in HOLD. A higher-priority request arriving during HOLD does not pre-empt it; it is granted on the next IDLE pass.
- Overflow:
  - Set when rise[i] & pending[i] & ~clear[i] for any i.
  - Cleared by clr_ovf.
  - Set wins if it coincides with clr_ovf.
  - In EDGE=0 mode a held-high request sets overflow on the second cycle.
- Reset values: pending=0, req_q=0, out_valid=0, out_idx=0, overflow=0, state=IDLE.
  - rst mid-HOLD drops out_valid on the next edge without any handshake.
  - EDGE=1: a request already high when rst deasserts counts as a rising edge on the first cycle.

## Timing
- Latency from request to grant: req_in rises before edge t, pending set at edge t, out_valid=1 after edge t+1.
- Throughput is at most one grant per 2 cycles (HOLD -> IDLE -> HOLD).
- out_ready high while out_valid=0 is ignored.
- out_ready may stay high permanently; grants then complete one cycle after out_valid rises.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package/header holds:
  - request width constant (4);
  - index width constant (2);
  - FSM state encodings IDLE=0, HOLD=1.
- One sub-module, pe_encode4: combinational 4->2 highest-index-wins encoder used on pending. It matches the downstream encoder rule so that both agree on priority.
- Top level holds req_q, pending, the FSM, the output registers and the overflow logic.

## Test plan
- Single request: reset, pulse req_in=4'b0100 for 1 cycle.
  - pending=4'b0100 after 1 edge; out_valid=1, out_idx=2 after the next edge.
  - With out_ready=1: pending=0, out_valid=0 one cycle later.
- Priority: req_in=4'b1011 for 1 cycle, out_ready=1. Grants arrive in order out_idx=3, 1, 0, each 2 cycles apart; overflow stays 0.
- Stall: out_ready=0 for 5 cycles with pending=4'b0001, then raise req_in bit 3.
  - out_idx stays 0 (no pre-emption) until the handshake; the next grant is 3.
- Overflow: in EDGE=1, pulse bit 1 twice while out_ready=0 -> overflow=1.
  - Clear with clr_ovf -> overflow=0.
  - Assert clr_ovf on the same cycle as a new overflow event -> overflow stays 1.
- Set/clear collision: bit 2 granted; in the handshake cycle bit 2 rises again. pending[2] stays 1 and a second grant of 2 follows.
- Reset mid-HOLD: assert rst while out_valid=1 -> next cycle all outputs are 0.
  - In EDGE=1 mode, with req_in=4'b1000 held through reset, the first grant after release is out_idx=3.

Source files
------------

// File: rtl/req_capture_pe_pkg.sv
// req_capture_pe shared definitions
// widths, FSM states and index helper
package req_capture_pe_pkg;

  localparam int REQ_W = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [REQ_W-1:0] idx2oh(
    input logic [IDX_W-1:0] i
  );
    logic [REQ_W-1:0] one;
    one = REQ_W'(1);
    return one << i;
  endfunction

endpackage

// File: rtl/req_capture_pe_encode.sv
// pe_encode4: 4->2 highest-index-wins encoder
// same priority rule as the downstream encoder
module pe_encode4
  import req_capture_pe_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // bit 3 has top priority, zero input gives idx 0 and any=0
  always_comb begin
    idx = '0;
    any = |req;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    else             idx = 2'd0;
  end

endmodule

// File: rtl/req_capture_pe.sv
// req_capture_pe: request capture and grant
// pending register, frozen grant, sticky overflow
module req_capture_pe
  import req_capture_pe_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] req_in,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [REQ_W-1:0] pending,
  output logic             overflow
);

  logic [REQ_W-1:0] req_q;
  logic [REQ_W-1:0] rise;
  logic [REQ_W-1:0] clear;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             ovf_set;
  state_t           state;

  pe_encode4 u_enc (
    .req (pending),
    .idx (enc_idx),
    .any (enc_any)
  );

  // new requests, serviced-bit mask and overflow event
  always_comb begin
    rise    = EDGE ? (req_in & ~req_q) : req_in;
    clear   = (out_valid && out_ready) ? idx2oh(out_idx) : '0;
    ovf_set = |(rise & pending & ~clear);
  end

  // capture: set wins over clear, overflow set wins over clr_ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      req_q    <= req_in;
      pending  <= (pending & ~clear) | rise;
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

  // grant FSM: grant frozen in HOLD until the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enc_any) begin
            out_idx   <= enc_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_capture_pe.sv
// tb_req_capture_pe: directed vectors
// edge-mode DUT plus a level-mode DUT
module tb_req_capture_pe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] pending;
  logic       overflow;

  logic [3:0] req_l = '0;
  logic       rdy_l = 1'b0;
  logic       clr_l = 1'b0;
  logic       val_l;
  logic [1:0] idx_l;
  logic [3:0] pend_l;
  logic       ovf_l;

  int n_cmp = 0;
  int n_err = 0;

  req_capture_pe #(.EDGE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  req_capture_pe #(.EDGE(1'b0)) dut_lvl (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_l),
    .out_ready (rdy_l),
    .clr_ovf   (clr_l),
    .out_valid (val_l),
    .out_idx   (idx_l),
    .pending   (pend_l),
    .overflow  (ovf_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] ei;
    logic [3:0] ep;
    logic       eo;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] q,
    input logic y, input logic c,
    input logic v, input logic [1:0] i,
    input logic [3:0] p, input logic o
  );
    vec_t t;
    t.rst = r; t.req = q; t.rdy = y; t.clr = c;
    t.ev = v; t.ei = i; t.ep = p; t.eo = o;
    return t;
  endfunction

  task automatic chk(
    input string nm, input int act, input int exp
  );
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string nm, input logic v, input logic [1:0] i,
    input logic [3:0] p, input logic o
  );
    chk({nm, ".valid"}, int'(out_valid), int'(v));
    if (v) chk({nm, ".idx"}, int'(out_idx), int'(i));
    chk({nm, ".pending"}, int'(pending), int'(p));
    chk({nm, ".ovf"}, int'(overflow), int'(o));
  endtask

  initial begin
    // rst req rdy clr | valid idx pending ovf
    tv.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
    // single request
    tv.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // priority 1011 with ready held
    tv.push_back(mk(0, 4'b1011, 1, 0, 0, 0, 4'b1011, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 1, 3, 4'b1011, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0011, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 4'b0011, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0001, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // overflow: bit 1 twice, clear, collide with clr
    tv.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0));
    tv.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'b0010, 0));
    tv.push_back(mk(0, 4'b0010, 0, 0, 1, 1, 4'b0010, 1));
    tv.push_back(mk(0, 4'b0000, 0, 1, 1, 1, 4'b0010, 0));
    tv.push_back(mk(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 1));
    tv.push_back(mk(0, 4'b0000, 0, 1, 1, 1, 4'b0010, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // set/clear collision on bit 2
    tv.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0000, 0, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0100, 0, 0, 1, 2, 4'b0100, 1));
    // reset mid-HOLD, bit 3 held through reset
    tv.push_back(mk(1, 4'b1000, 0, 0, 0, 0, 4'b0000, 0));
    tv.push_back(mk(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0));
    tv.push_back(mk(0, 4'b1000, 0, 0, 1, 3, 4'b1000, 0));

    for (int k = 0; k < tv.size(); k++) begin
      rst       = tv[k].rst;
      req_in    = tv[k].req;
      out_ready = tv[k].rdy;
      clr_ovf   = tv[k].clr;
      step();
      chk_all($sformatf("v%0d", k), tv[k].ev, tv[k].ei,
              tv[k].ep, tv[k].eo);
    end

    // finish the bit-3 grant
    out_ready = 1'b1;
    step();
    chk_all("drain", 1'b0, 2'd0, 4'b0000, 1'b0);

    // stall: bit 0 held 5 cycles, bit 3 arrives mid-stall
    req_in = 4'b0000;
    out_ready = 1'b0;
    step();
    req_in = 4'b0001;
    step();
    req_in = 4'b0000;
    step();
    chk_all("stall.g0", 1'b1, 2'd0, 4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      req_in = (c == 1) ? 4'b1000 : 4'b0000;
      step();
      chk_all($sformatf("stall.c%0d", c), 1'b1, 2'd0,
              (c >= 1) ? 4'b1001 : 4'b0001, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk_all("stall.hs", 1'b0, 2'd0, 4'b1000, 1'b0);
    step();
    chk_all("stall.g3", 1'b1, 2'd3, 4'b1000, 1'b0);
    step();
    chk_all("stall.end", 1'b0, 2'd0, 4'b0000, 1'b0);
    out_ready = 1'b0;

    // level mode: held request overflows on 2nd cycle
    chk("lvl.idle.pend", int'(pend_l), 0);
    req_l = 4'b0100;
    step();
    chk("lvl.c1.pend", int'(pend_l), 4);
    chk("lvl.c1.ovf", int'(ovf_l), 0);
    chk("lvl.c1.valid", int'(val_l), 0);
    step();
    chk("lvl.c2.ovf", int'(ovf_l), 1);
    chk("lvl.c2.valid", int'(val_l), 1);
    chk("lvl.c2.idx", int'(idx_l), 2);
    req_l = 4'b0000;
    rdy_l = 1'b1;
    clr_l = 1'b1;
    step();
    chk("lvl.c3.pend", int'(pend_l), 0);
    chk("lvl.c3.valid", int'(val_l), 0);
    chk("lvl.c3.ovf", int'(ovf_l), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
